// File: rtl/fb_scan_ram.sv
// fb_scan_ram: single-clock framebuffer with a random-access pixel write port,
// a hardware clear engine and a streaming scan-out port.
//
// Ports:
//   clk, resetn              single rising-edge clock, asynchronous active-low reset
//   wr_valid/wr_ready        pixel write handshake, wr_addr/wr_data carried with it
//   wr_err                   1-cycle pulse after an accepted write that was out of range
//   clr_start / clr_busy     fill the buffer with CLR_VALUE, busy while filling
//   scan_start / scan_stop   begin a scan pass / end a continuous scan
//   scan_busy                scan sequencer in SCAN or DRAIN
//   out_valid/out_ready      scan-out handshake, out_data/out_first/out_last carried with it
//   dbg_state                current FSM state (IDLE=0, CLEAR=1, SCAN=2, DRAIN=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. A producer holding valid keeps its payload stable until that edge; valid
// never drops without a transfer. ready may change freely.

module fb_scan_ram #(
    parameter int                  PIX_BITS   = 2,
    parameter int                  FB_DEPTH   = 24576,
    parameter int                  ADDR_W     = 15,
    parameter logic [PIX_BITS-1:0] CLR_VALUE  = '0,
    parameter bit                  CONTINUOUS = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PIX_BITS-1:0] wr_data,
    output logic                wr_err,
    input  logic                clr_start,
    output logic                clr_busy,
    input  logic                scan_start,
    input  logic                scan_stop,
    output logic                scan_busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_BITS-1:0] out_data,
    output logic                out_first,
    output logic                out_last,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam int IDX_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    // Skid entry layout: {first, last, pixel}
    localparam int EW = PIX_BITS + 2;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;      // clear counter or scan read address
    logic                wr_ready_q, wr_ready_d;
    logic                wr_err_q, wr_err_d;
    logic                rd_pend_q, rd_pend_d; // read issued last cycle, data in rd_data_q
    logic                rd_first_q, rd_first_d;
    logic                rd_last_q, rd_last_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [EW-1:0]       e0_q, e0_d;          // head of skid buffer
    logic [EW-1:0]       e1_q, e1_d;

    logic [PIX_BITS-1:0] mem [FB_DEPTH];
    logic [PIX_BITS-1:0] rd_data_q;

    logic                pop;
    logic                rd_en;
    logic [1:0]          occ;
    logic                wr_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [PIX_BITS-1:0] mem_wd;
    logic [EW-1:0]       new_ent;

    assign pop = (fifo_cnt_q != 2'd0) && out_ready;

    // Slots still claimed after this cycle's pop: buffered plus the read in flight.
    // A new read is issued only if it is guaranteed a slot when it lands.
    assign occ   = fifo_cnt_q + 2'(rd_pend_q) - 2'(pop);
    assign rd_en = (state_q == S_SCAN) && (occ < 2'd2) && !(CONTINUOUS && scan_stop);

    // wr_ready_q is low throughout CLEAR, so the clear engine owns the write port there.
    assign wr_ok  = wr_valid && wr_ready_q && (wr_addr <= LAST_ADDR);
    assign mem_we = (state_q == S_CLEAR) || wr_ok;
    assign mem_wa = (state_q == S_CLEAR) ? addr_q : wr_addr;
    assign mem_wd = (state_q == S_CLEAR) ? CLR_VALUE : wr_data;

    assign new_ent = {rd_first_q, rd_last_q, rd_data_q};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                end else if (scan_start) begin
                    state_d = S_SCAN;
                    addr_d  = '0;
                end
            end
            S_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_SCAN: begin
                if (CONTINUOUS && scan_stop) begin
                    state_d = S_DRAIN;
                end else if (rd_en) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        if (!CONTINUOUS) state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == 2'd0 && !rd_pend_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready_d = (state_d != S_CLEAR);
        wr_err_d   = wr_valid && wr_ready_q && (wr_addr > LAST_ADDR);
        rd_pend_d  = rd_en;
        rd_first_d = (addr_q == '0);
        rd_last_d  = (addr_q == LAST_ADDR);
    end

    // Skid buffer: e0 is always the head, so a stalled head never moves.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        e0_d       = e0_q;
        e1_d       = e1_q;
        case ({rd_pend_q, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) e0_d = new_ent;
                else                    e1_d = new_ent;
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d       = e1_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    e0_d = new_ent;
                end else begin
                    e0_d = e1_q;
                    e1_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            e0_q       <= '0;
            e1_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            rd_pend_q  <= rd_pend_d;
            rd_first_q <= rd_first_d;
            rd_last_q  <= rd_last_d;
            fifo_cnt_q <= fifo_cnt_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
        end
    end

    // RAM array and its read register carry no reset so the array maps onto block RAM.
    // Both ports in one block with non-blocking updates gives read-first collisions.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa[IDX_W-1:0]] <= mem_wd;
        if (rd_en)  rd_data_q <= mem[addr_q[IDX_W-1:0]];
    end

    assign wr_ready  = wr_ready_q;
    assign wr_err    = wr_err_q;
    assign clr_busy  = (state_q == S_CLEAR);
    assign scan_busy = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = e0_q[PIX_BITS-1:0];
    assign out_last  = out_valid && e0_q[PIX_BITS];
    assign out_first = out_valid && e0_q[PIX_BITS+1];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_scan_ram.sv
// Bench for fb_scan_ram: a one-shot instance (dut) and a continuous-scan
// instance (dut_c), both with a small FB_DEPTH so full passes stay short.

module tb_fb_scan_ram;

  localparam int PB = 2;
  localparam int D  = 40;
  localparam int AW = 15;
  localparam logic [1:0] CLR0 = 2'b01;
  localparam logic [1:0] CLRC = 2'b10;
  localparam int NC = 100;  // 2.5 passes of the continuous instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut signals ----------------
  logic          wr_valid = 1'b0, wr_ready, wr_err;
  logic [AW-1:0] wr_addr = '0;
  logic [PB-1:0] wr_data = '0;
  logic          clr_start = 1'b0, clr_busy;
  logic          scan_start = 1'b0, scan_stop = 1'b0, scan_busy;
  logic          out_valid, out_ready = 1'b0, out_first, out_last;
  logic [PB-1:0] out_data;
  logic [1:0]    dbg_state;

  logic          c_wr_valid = 1'b0, c_wr_ready, c_wr_err;
  logic [AW-1:0] c_wr_addr = '0;
  logic [PB-1:0] c_wr_data = '0;
  logic          c_clr_start = 1'b0, c_clr_busy;
  logic          c_scan_start = 1'b0, c_scan_stop = 1'b0, c_scan_busy;
  logic          c_out_valid, c_out_ready = 1'b1, c_out_first, c_out_last;
  logic [PB-1:0] c_out_data;
  logic [1:0]    c_dbg_state;

  fb_scan_ram #(.PIX_BITS(PB), .FB_DEPTH(D), .ADDR_W(AW), .CLR_VALUE(CLR0), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .scan_start(scan_start), .scan_stop(scan_stop), .scan_busy(scan_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .dbg_state(dbg_state)
  );

  fb_scan_ram #(.PIX_BITS(PB), .FB_DEPTH(D), .ADDR_W(AW), .CLR_VALUE(CLRC), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .resetn(resetn),
    .wr_valid(c_wr_valid), .wr_ready(c_wr_ready), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_err(c_wr_err),
    .clr_start(c_clr_start), .clr_busy(c_clr_busy),
    .scan_start(c_scan_start), .scan_stop(c_scan_stop), .scan_busy(c_scan_busy),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_first(c_out_first), .out_last(c_out_last), .dbg_state(c_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [3:0]    exp_q[$];   // {first, last, pixel}
  logic [3:0]    expc_q[$];
  logic [PB-1:0] model[D];
  logic [PB-1:0] model_c[D];
  bit            mon_c_en = 1'b1;
  int            c_first_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for dut: pops on each transfer, and checks a stalled head stays put.
  bit         hold = 1'b0;
  logic [3:0] held;
  always @(negedge clk) begin
    if (hold) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_stable", 32'({out_first, out_last, out_data}), 32'(held));
    end
    hold = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pixel: got %0h expected none at %0t", {out_first, out_last, out_data}, $time);
        end else begin
          check("pixel", 32'({out_first, out_last, out_data}), 32'(exp_q.pop_front()));
        end
      end else begin
        hold = 1'b1;
        held = {out_first, out_last, out_data};
      end
    end
  end

  // Monitor for dut_c
  always @(negedge clk) begin
    if (mon_c_en && c_out_valid && c_out_ready) begin
      if (c_out_first) c_first_cnt++;
      if (expc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL c_extra_pixel: got %0h expected none at %0t", {c_out_first, c_out_last, c_out_data}, $time);
      end else begin
        check("c_pixel", 32'({c_out_first, c_out_last, c_out_data}), 32'(expc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [PB-1:0] d, input bit exp_err);
    check("wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    check("wr_err", 32'(wr_err), 32'(exp_err));
    if (!exp_err) model[int'(a)] = d;
    tick();
    check("wr_err_pulse", 32'(wr_err), 32'd0);
  endtask

  task automatic do_clear(input bit with_scan);
    int n;
    clr_start  = 1'b1;
    scan_start = with_scan;
    tick();
    clr_start  = 1'b0;
    scan_start = 1'b0;
    n = 0;
    while (clr_busy && n < 4 * D) begin
      n++;
      if (n == 1) begin
        check("clr_wr_ready", 32'(wr_ready), 32'd0);
        check("clr_scan_idle", 32'(scan_busy), 32'd0);
      end
      if (with_scan && n == 5) scan_start = 1'b1;
      if (n == 6) scan_start = 1'b0;
      tick();
    end
    check("clr_busy_cycles", 32'(n), 32'(D));
    check("clr_scan_ignored", 32'(scan_busy), 32'd0);
    check("clr_no_output", 32'(out_valid), 32'd0);
    check("clr_wr_ready_back", 32'(wr_ready), 32'd1);
    for (int a = 0; a < D; a++) model[a] = CLR0;
  endtask

  task automatic run_scan(input bit rand_ready, input bit timing, input int coll);
    int k, first_k, vcnt;
    for (int a = 0; a < D; a++) exp_q.push_back({a == 0, a == D - 1, model[a]});
    scan_start = 1'b1;
    out_ready  = 1'b1;
    tick();
    scan_start = 1'b0;
    k = 0;
    first_k = -1;
    vcnt = 0;
    while (scan_busy && k < 20 * D) begin
      if (out_valid) begin
        vcnt++;
        if (first_k < 0) first_k = k;
      end
      // Write lands on the same edge that reads address coll.
      if (coll >= 0 && k == coll) begin
        wr_valid = 1'b1;
        wr_addr  = AW'(coll);
        wr_data  = 2'd3;
      end
      if (coll >= 0 && k == coll + 1) begin
        wr_valid = 1'b0;
        check("coll_wr_err", 32'(wr_err), 32'd0);
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check("scan_done", 32'(scan_busy), 32'd0);
    check("scan_queue_empty", 32'(exp_q.size()), 32'd0);
    if (timing) begin
      check("first_valid_latency", 32'(first_k), 32'd2);
      check("valid_beats", 32'(vcnt), 32'(D));
    end
    out_ready = 1'b1;
  endtask

  task automatic c_write(input logic [AW-1:0] a, input logic [PB-1:0] d);
    c_wr_valid = 1'b1;
    c_wr_addr  = a;
    c_wr_data  = d;
    tick();
    c_wr_valid = 1'b0;
    model_c[int'(a)] = d;
  endtask

  task automatic run_cont();
    int k;
    for (int i = 0; i < NC; i++)
      expc_q.push_back({(i % D) == 0, (i % D) == D - 1, model_c[i % D]});
    c_first_cnt  = 0;
    c_scan_start = 1'b1;
    tick();
    c_scan_start = 1'b0;
    k = 0;
    while (c_scan_busy && k < 20 * D) begin
      // Stop sampled on edge NC+1, so reads 0..NC-1 are issued.
      if (k == NC) c_scan_stop = 1'b1;
      if (k == NC + 1) c_scan_stop = 1'b0;
      tick();
      k++;
    end
    check("c_scan_done", 32'(c_scan_busy), 32'd0);
    check("c_queue_empty", 32'(expc_q.size()), 32'd0);
    check("c_first_count", 32'(c_first_cnt), 32'd3);
    check("c_state_idle", 32'(c_dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    tick();
    tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_scan_busy", 32'(scan_busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    resetn = 1'b1;
    tick();
    check("wr_ready_after_rst", 32'(wr_ready), 32'd1);

    // Clear, then full scan returns CLR0 everywhere
    do_clear(1'b0);
    run_scan(1'b0, 1'b1, -1);

    // Directed pixels with first/last tagging and back-to-back beats
    do_write(AW'(0), 2'd3, 1'b0);
    do_write(AW'(1), 2'd2, 1'b0);
    do_write(AW'(D - 1), 2'd1, 1'b0);
    run_scan(1'b0, 1'b1, -1);

    // Same sequence under random backpressure
    run_scan(1'b1, 1'b0, -1);

    // Out-of-range writes are dropped and flagged
    do_write(AW'(D), 2'd2, 1'b1);
    do_write(AW'(24576), 2'd2, 1'b1);
    do_write(AW'(32767), 2'd2, 1'b1);
    // Read-first collision: address 5 holds 0 when written with 3 mid-scan
    do_write(AW'(5), 2'd0, 1'b0);
    run_scan(1'b0, 1'b0, 5);
    model[5] = 2'd3;
    run_scan(1'b0, 1'b0, -1);

    // clr_start and scan_start together, and scan_start during CLEAR
    do_clear(1'b1);
    run_scan(1'b0, 1'b0, -1);

    // Continuous instance
    c_clr_start = 1'b1;
    tick();
    c_clr_start = 1'b0;
    n = 0;
    while (c_clr_busy && n < 4 * D) begin
      n++;
      tick();
    end
    check("c_clr_cycles", 32'(n), 32'(D));
    for (int a = 0; a < D; a++) model_c[a] = CLRC;
    c_write(AW'(0), 2'd3);
    c_write(AW'(20), 2'd0);
    c_write(AW'(D - 1), 2'd1);
    run_cont();

    // Reset during a continuous scan clears outputs without waiting for a clock
    mon_c_en = 1'b0;
    c_scan_start = 1'b1;
    tick();
    c_scan_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("c_scanning", 32'(c_out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_out_valid", 32'(c_out_valid), 32'd0);
    check("async_scan_busy", 32'(c_scan_busy), 32'd0);
    check("async_state", 32'(c_dbg_state), 32'd0);
    check("async_out_first", 32'(c_out_first), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
